// File: rtl/serial_mul_scheduler.sv
// Shares one bit-serial signed multiplier among NREQ requesters with round-robin arbitration.
// Each op runs FLUSH, LOAD and RUN, and the tagged product is then held in DONE until it is accepted.
module serial_mul_scheduler #(
    parameter int BITWIDTH = 8,
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int CW       = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*BITWIDTH-1:0] req_a,
    input  logic [NREQ*BITWIDTH-1:0] req_b,
    output logic [NREQ-1:0]          gnt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*BITWIDTH-1:0]    out_data,
    output logic [IDW-1:0]           out_id,
    output logic                     busy,
    output logic                     mul_in_valid,
    output logic [BITWIDTH-1:0]      mul_a,
    output logic [BITWIDTH-1:0]      mul_b,
    output logic [CW-1:0]            mul_last_count,
    output logic                     mul_metronome,
    input  logic                     mul_dout_valid,
    input  logic [2*BITWIDTH-1:0]    mul_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(BITWIDTH - 1);
    localparam logic [CW-1:0] CNT_MET  = CW'(BITWIDTH - 2);

    state_t                       state;
    state_t                       state_nxt;
    logic [IDW-1:0]               rr_ptr;
    logic [IDW-1:0]               gid;
    logic [IDW-1:0]               pick_id;
    logic                         pick_vld;
    logic signed [BITWIDTH-1:0]   opa;
    logic signed [BITWIDTH-1:0]   opb;
    logic [CW-1:0]                cnt;
    logic signed [2*BITWIDTH-1:0] res;
    logic [IDW-1:0]               res_id;
    logic                         err;

    // Descending scan so the requester closest to rr_ptr (k = 0) is the last one written and wins.
    always_comb begin : arbiter
        int idx;
        pick_vld = 1'b0;
        pick_id  = '0;
        idx      = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (req[idx]) begin
                pick_vld = 1'b1;
                pick_id  = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            gid    <= '0;
            opa    <= '0;
            opb    <= '0;
            cnt    <= '0;
            res    <= '0;
            res_id <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        gid <= pick_id;
                        opa <= req_a[pick_id*BITWIDTH +: BITWIDTH];
                        opb <= req_b[pick_id*BITWIDTH +: BITWIDTH];
                    end
                end
                S_LOAD: cnt <= '0;
                S_RUN: begin
                    if (cnt == CNT_LAST) begin
                        res    <= mul_dout;
                        res_id <= gid;
                        if (!mul_dout_valid) err <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) rr_ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + IDW'(1);
                end
                default: ;
            endcase
        end
    end

    // gnt is gated by rst so a held request cannot show a grant while reset is asserted.
    always_comb begin
        state_nxt      = state;
        gnt            = '0;
        mul_in_valid   = 1'b0;
        mul_metronome  = 1'b0;
        mul_last_count = '0;
        out_valid      = 1'b0;
        busy           = (state != S_IDLE);
        mul_a          = '0;
        mul_b          = '0;
        case (state)
            S_IDLE: begin
                if (pick_vld && rst) begin
                    gnt[pick_id] = 1'b1;
                    state_nxt    = S_FLUSH;
                end
            end
            S_FLUSH: begin
                mul_metronome = 1'b1;
                state_nxt     = S_LOAD;
            end
            S_LOAD: begin
                mul_in_valid = 1'b1;
                state_nxt    = S_RUN;
            end
            S_RUN: begin
                mul_last_count = cnt;
                mul_metronome  = (cnt == CNT_MET);
                if (cnt == CNT_LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (state != S_IDLE) begin
            mul_a = opa;
            mul_b = opb;
        end
    end

    assign out_data = res;
    assign out_id   = res_id;

    // The multiplier must present its product exactly on the final bit step.
    a_dout_aligned: assert property (@(posedge clk) disable iff (!rst) !err);

endmodule

// File: tb/tb_serial_mul_scheduler.sv
// Scoreboard bench for serial_mul_scheduler with a behavioural bit-serial multiplier stand-in.
// A grant pushes the expected tagged product, and each scenario task pops and checks the results.
module tb_serial_mul_scheduler;
    localparam int BW   = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CW   = 5;

    typedef struct {
        logic [IDW-1:0]  id;
        logic [2*BW-1:0] prod;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req = '0;
    logic [NREQ*BW-1:0] req_a = '0;
    logic [NREQ*BW-1:0] req_b = '0;
    logic               out_ready = 1'b1;
    logic [NREQ-1:0]    gnt;
    logic               out_valid;
    logic [2*BW-1:0]    out_data;
    logic [IDW-1:0]     out_id;
    logic               busy;
    logic               mul_in_valid;
    logic [BW-1:0]      mul_a;
    logic [BW-1:0]      mul_b;
    logic [CW-1:0]      mul_last_count;
    logic               mul_metronome;
    logic               mul_dout_valid;
    logic [2*BW-1:0]    mul_dout;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    int   gq[$];

    serial_mul_scheduler #(.BITWIDTH(BW), .NREQ(NREQ), .IDW(IDW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .gnt(gnt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
        .busy(busy), .mul_in_valid(mul_in_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_last_count(mul_last_count), .mul_metronome(mul_metronome),
        .mul_dout_valid(mul_dout_valid), .mul_dout(mul_dout)
    );

    function automatic logic [2*BW-1:0] mprod(input logic signed [BW-1:0] a, input logic signed [BW-1:0] b);
        logic signed [2*BW-1:0] ea;
        logic signed [2*BW-1:0] eb;
        ea = a;
        eb = b;
        return ea * eb;
    endfunction

    // Multiplier stand-in: captures on mul_in_valid, echoes metronome one cycle later.
    logic [BW-1:0] ma;
    logic [BW-1:0] mb;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_dout_valid <= 1'b0;
            ma <= '0;
            mb <= '0;
        end else begin
            mul_dout_valid <= mul_metronome;
            if (mul_in_valid) begin
                ma <= mul_a;
                mb <= mul_b;
            end
        end
    end
    assign mul_dout = mul_dout_valid ? mprod(ma, mb) : 16'hDEAD;

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                e.id   = IDW'(i);
                e.prod = mprod(req_a[i*BW +: BW], req_b[i*BW +: BW]);
                sb.push_back(e);
                gq.push_back(i);
            end
        end
    end

    task automatic wait_out(input int maxc, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < maxc) begin
            @(negedge clk);
            cyc++;
            if (out_valid) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        req   = '1;
        req_a = 32'h1234_5678;
        req_b = 32'h9ABC_DEF0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({gnt, out_valid, busy, mul_in_valid, mul_metronome, mul_last_count, mul_a, mul_b, out_data, out_id} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got gnt=%b ov=%b busy=%b mlc=%0d ma=%h mb=%h od=%h oid=%0d, all required 0",
                     gnt, out_valid, busy, mul_last_count, mul_a, mul_b, out_data, out_id);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL reset_no_grant: got %0d grants, required 0", sb.size());
        end
        sb.delete();
        gq.delete();
        req = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        bit got;
        int cyc;
        exp_t e;
        req_a = '0;
        req_b = '0;
        req_a[BW-1:0] = 8'd3;
        req_b[BW-1:0] = 8'd5;
        out_ready = 1'b1;
        req = 4'b0001;
        @(negedge clk);
        n_cmp++;
        if (gnt !== 4'b0001) begin n_err++; $display("FAIL single_gnt: got %b required 0001", gnt); end
        @(posedge clk);
        #1 req = '0;
        wait_out(40, got, cyc);
        n_cmp++;
        if (!got || cyc != BW + 3) begin n_err++; $display("FAIL single_latency: got valid=%0d after %0d cycles, required %0d", got, cyc, BW + 3); end
        n_cmp++;
        if (out_data !== 16'd15 || out_id !== 2'd0) begin n_err++; $display("FAIL single_result: got %h/id%0d required 000f/id0", out_data, out_id); end
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL single_sb: scoreboard empty, required 1 entry"); end
        else begin
            e = sb.pop_front();
            if (out_data !== e.prod || out_id !== e.id) begin n_err++; $display("FAIL single_sb: got %h/id%0d required %h/id%0d", out_data, out_id, e.prod, e.id); end
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got ov=%b busy=%b required 0/0", out_valid, busy); end
    endtask

    task automatic test_signed();
        bit got;
        int cyc;
        exp_t e;
        int ids[2] = '{1, 2};
        logic [BW-1:0] av[2] = '{8'hF9, 8'h80};
        logic [BW-1:0] bv[2] = '{8'h06, 8'h80};
        logic [2*BW-1:0] pv[2] = '{16'hFFD6, 16'h4000};
        for (int t = 0; t < 2; t++) begin
            @(posedge clk);
            #1;
            req_a = '0;
            req_b = '0;
            req_a[ids[t]*BW +: BW] = av[t];
            req_b[ids[t]*BW +: BW] = bv[t];
            req = '0;
            req[ids[t]] = 1'b1;
            @(posedge clk);
            #1 req = '0;
            wait_out(40, got, cyc);
            n_cmp++;
            if (!got || out_data !== pv[t] || out_id !== IDW'(ids[t])) begin
                n_err++;
                $display("FAIL signed_%0d: got valid=%0d %h/id%0d required %h/id%0d", t, got, out_data, out_id, pv[t], ids[t]);
            end
            n_cmp++;
            if (sb.size() == 0) begin n_err++; $display("FAIL signed_sb_%0d: scoreboard empty", t); end
            else begin
                e = sb.pop_front();
                if (out_data !== e.prod || out_id !== e.id) begin n_err++; $display("FAIL signed_sb_%0d: got %h/id%0d required %h/id%0d", t, out_data, out_id, e.prod, e.id); end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_round_robin();
        bit got;
        int cyc;
        exp_t e;
        @(posedge clk);
        #1 rst = 1'b0;
        #2 rst = 1'b1;
        sb.delete();
        gq.delete();
        req_a = {8'hFE, 8'd7, 8'h85, 8'd13};
        req_b = {8'd9, 8'hF3, 8'd2, 8'h7F};
        out_ready = 1'b1;
        req = '1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                @(posedge clk);
                @(posedge clk);
                #1 req = '0;
            end
            wait_out(60, got, cyc);
            n_cmp++;
            if (!got || out_id !== IDW'(k % NREQ)) begin n_err++; $display("FAIL rr_order_%0d: got valid=%0d id%0d required id%0d", k, got, out_id, k % NREQ); end
            if (k >= 1 && k < 4) begin
                n_cmp++;
                if (cyc != BW + 4) begin n_err++; $display("FAIL rr_throughput_%0d: got %0d cycles required %0d", k, cyc, BW + 4); end
            end
            n_cmp++;
            if (gq.size() <= k || gq[k] != k % NREQ) begin n_err++; $display("FAIL rr_gnt_%0d: got %0d grants logged, required grant %0d", k, gq.size(), k % NREQ); end
            n_cmp++;
            if (sb.size() == 0) begin n_err++; $display("FAIL rr_sb_%0d: scoreboard empty", k); end
            else begin
                e = sb.pop_front();
                if (out_data !== e.prod || out_id !== e.id) begin n_err++; $display("FAIL rr_sb_%0d: got %h/id%0d required %h/id%0d", k, out_data, out_id, e.prod, e.id); end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        bit got;
        int cyc;
        exp_t e;
        req_a = {8'd0, 8'd5, 8'hFF, 8'd100};
        req_b = {8'd0, 8'hF7, 8'd77, 8'd2};
        req = 4'b0100;
        @(negedge clk);
        n_cmp++;
        if (gnt !== 4'b0100) begin n_err++; $display("FAIL wrap_setup_gnt: got %b required 0100", gnt); end
        @(posedge clk);
        #1 req = 4'b0011;
        wait_out(40, got, cyc);
        n_cmp++;
        if (sb.size() == 0 || !got) begin n_err++; $display("FAIL wrap_setup_sb: valid=%0d entries=%0d", got, sb.size()); end
        else begin
            e = sb.pop_front();
            if (out_data !== e.prod || out_data !== 16'hFFD3) begin n_err++; $display("FAIL wrap_setup_sb: got %h required %h and ffd3", out_data, e.prod); end
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (gnt !== 4'b0001) begin n_err++; $display("FAIL wrap_gnt0: got %b required 0001", gnt); end
        @(posedge clk);
        #1 req = 4'b0010;
        wait_out(40, got, cyc);
        n_cmp++;
        if (sb.size() == 0 || !got) begin n_err++; $display("FAIL wrap_sb0: valid=%0d entries=%0d", got, sb.size()); end
        else begin
            e = sb.pop_front();
            if (out_data !== e.prod || out_id !== 2'd0) begin n_err++; $display("FAIL wrap_sb0: got %h/id%0d required %h/id0", out_data, out_id, e.prod); end
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (gnt !== 4'b0010) begin n_err++; $display("FAIL wrap_gnt1: got %b required 0010", gnt); end
        @(posedge clk);
        #1 req = '0;
        wait_out(40, got, cyc);
        n_cmp++;
        if (sb.size() == 0 || !got) begin n_err++; $display("FAIL wrap_sb1: valid=%0d entries=%0d", got, sb.size()); end
        else begin
            e = sb.pop_front();
            if (out_data !== e.prod || out_id !== 2'd1) begin n_err++; $display("FAIL wrap_sb1: got %h/id%0d required %h/id1", out_data, out_id, e.prod); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        bit got;
        int cyc;
        exp_t e;
        logic [2*BW-1:0] d;
        logic [IDW-1:0] i;
        out_ready = 1'b0;
        req_a = {8'd0, 8'd0, 8'hFE, 8'd11};
        req_b = {8'd0, 8'd0, 8'hCE, 8'hFD};
        req = 4'b0001;
        @(posedge clk);
        #1 req = 4'b0010;
        wait_out(40, got, cyc);
        d = out_data;
        i = out_id;
        n_cmp++;
        if (!got || d !== 16'hFFDF || i !== 2'd0) begin n_err++; $display("FAIL bp_result: valid=%0d got %h/id%0d required ffdf/id0", got, d, i); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== d || out_id !== i || gnt !== '0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got ov=%b od=%h id=%0d gnt=%b busy=%b required 1/%h/%0d/0000/1", c, out_valid, out_data, out_id, gnt, busy, d, i);
            end
        end
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL bp_sb0: scoreboard empty"); end
        else begin
            e = sb.pop_front();
            if (d !== e.prod || i !== e.id) begin n_err++; $display("FAIL bp_sb0: got %h/id%0d required %h/id%0d", d, i, e.prod, e.id); end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (gnt !== 4'b0010) begin n_err++; $display("FAIL bp_next_gnt: got %b required 0010", gnt); end
        @(posedge clk);
        #1 req = '0;
        wait_out(40, got, cyc);
        n_cmp++;
        if (sb.size() == 0 || !got) begin n_err++; $display("FAIL bp_sb1: valid=%0d entries=%0d", got, sb.size()); end
        else begin
            e = sb.pop_front();
            if (out_data !== e.prod || out_id !== e.id || out_data !== 16'd100) begin n_err++; $display("FAIL bp_sb1: got %h/id%0d required %h/id%0d", out_data, out_id, e.prod, e.id); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        bit got;
        int cyc;
        int nv;
        exp_t e;
        out_ready = 1'b1;
        req_a = {8'd0, 8'd9, 8'd0, 8'd0};
        req_b = {8'd0, 8'd9, 8'd0, 8'd0};
        req = 4'b0100;
        repeat (6) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({gnt, out_valid, busy, mul_in_valid, mul_metronome, mul_last_count, mul_a, mul_b, out_data, out_id} !== '0) begin
            n_err++;
            $display("FAIL midrun_reset: got gnt=%b ov=%b busy=%b mlc=%0d ma=%h mb=%h od=%h, all required 0",
                     gnt, out_valid, busy, mul_last_count, mul_a, mul_b, out_data);
        end
        sb.delete();
        repeat (2) @(posedge clk);
        #1 req = '0;
        rst = 1'b1;
        nv = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        n_cmp++;
        if (nv != 0) begin n_err++; $display("FAIL midrun_no_result: got %0d valid cycles required 0", nv); end
        @(posedge clk);
        #1;
        req_a = {8'hFF, 8'd0, 8'd0, 8'd0};
        req_b = {8'hFF, 8'd0, 8'd0, 8'd0};
        req = 4'b1000;
        @(negedge clk);
        n_cmp++;
        if (gnt !== 4'b1000) begin n_err++; $display("FAIL midrun_gnt: got %b required 1000", gnt); end
        @(posedge clk);
        #1 req = '0;
        wait_out(40, got, cyc);
        n_cmp++;
        if (!got || cyc != BW + 3 || out_data !== 16'd1 || out_id !== 2'd3) begin
            n_err++;
            $display("FAIL midrun_after: valid=%0d cyc=%0d got %h/id%0d required %0d cycles 0001/id3", got, cyc, out_data, out_id, BW + 3);
        end
        n_cmp++;
        if (sb.size() != 1) begin n_err++; $display("FAIL midrun_sb: got %0d entries required 1", sb.size()); end
        else begin
            e = sb.pop_front();
            if (out_data !== e.prod || out_id !== e.id) begin n_err++; $display("FAIL midrun_sb: got %h/id%0d required %h/id%0d", out_data, out_id, e.prod, e.id); end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_signed();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
